// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters through an issue/result pipeline.
// Define ALU_ARB_PERF_CNT_EN to add saturating per-requester grant counters (gnt_cnt0/gnt_cnt1).
module alu_rr_arbiter #(
  parameter int W   = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_x,
  input  logic [W-1:0]   req0_y,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_z,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_x,
  input  logic [W-1:0]   req1_y,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_z,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_z
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [15:0]    gnt_cnt0,
  output logic [15:0]    gnt_cnt1
`endif
);

  logic           r_a_valid;
  logic           r_a_id;
  logic [OPW-1:0] r_a_op;
  logic [W-1:0]   r_a_x;
  logic [W-1:0]   r_a_y;
  logic           r_b_valid;
  logic           r_b_id;
  logic [W-1:0]   r_b_z;
  logic           r_ptr;

  logic w_rsp_fire;
  logic w_b_adv;
  logic w_a_free;
  logic w_gnt0;
  logic w_gnt1;

  always_comb begin
    w_rsp_fire = r_b_valid && (r_b_id ? rsp1_ready : rsp0_ready);
    w_b_adv    = r_a_valid && (!r_b_valid || w_rsp_fire);
    w_a_free   = !r_a_valid || w_b_adv;
    // Pointer only breaks ties; a lone valid requester always wins.
    w_gnt0     = w_a_free && req0_valid && (!req1_valid || !r_ptr);
    w_gnt1     = w_a_free && req1_valid && (!req0_valid ||  r_ptr);
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign alu_x  = r_a_x;
  assign alu_y  = r_a_y;
  assign alu_op = r_a_op;

  assign rsp0_valid = r_b_valid && !r_b_id;
  assign rsp1_valid = r_b_valid &&  r_b_id;
  assign rsp0_z     = r_b_z;
  assign rsp1_z     = r_b_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_id    <= 1'b0;
      r_a_op    <= '0;
      r_a_x     <= '0;
      r_a_y     <= '0;
      r_b_valid <= 1'b0;
      r_b_id    <= 1'b0;
      r_b_z     <= '0;
      r_ptr     <= 1'b0;
    end else begin
      // Operand registers load only on grant so the ALU inputs hold while idle.
      if (w_gnt0 || w_gnt1) begin
        r_a_valid <= 1'b1;
        r_a_id    <= w_gnt1;
        r_a_op    <= w_gnt1 ? req1_op : req0_op;
        r_a_x     <= w_gnt1 ? req1_x  : req0_x;
        r_a_y     <= w_gnt1 ? req1_y  : req0_y;
        r_ptr     <= w_gnt0;
      end else if (w_a_free) begin
        r_a_valid <= 1'b0;
      end

      if (w_b_adv) begin
        r_b_valid <= 1'b1;
        r_b_id    <= r_a_id;
        r_b_z     <= alu_z;
      end else if (w_rsp_fire) begin
        r_b_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1 && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small ALU stub; expected values are hand-derived.
module tb_alu_rr_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_x, req0_y;
  logic        rsp0_valid, rsp0_ready;
  logic [15:0] rsp0_z;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_x, req1_y;
  logic        rsp1_valid, rsp1_ready;
  logic [15:0] rsp1_z;
  logic [15:0] alu_x, alu_y, alu_z;
  logic [3:0]  alu_op;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_checks;
  int n_errors;

  alu_rr_arbiter #(.W(16), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z)
`ifdef ALU_ARB_PERF_CNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // ALU stub: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pass X.
  always_comb begin
    case (alu_op)
      4'd0:    alu_z = alu_x + alu_y;
      4'd1:    alu_z = alu_x - alu_y;
      4'd2:    alu_z = alu_x & alu_y;
      4'd3:    alu_z = alu_x | alu_y;
      4'd4:    alu_z = alu_x ^ alu_y;
      default: alu_z = alu_x;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_op = '0; req1_x = '0; req1_y = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    tick();
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_x", alu_x, 0);
    check("rst_alu_y", alu_y, 0);
    check("rst_alu_op", alu_op, 0);

    // Single op from req0: 3 + 4.
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_x = 16'h0003; req0_y = 16'h0004;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_alu_x", alu_x, 16'h0003);
    check("t1_alu_y", alu_y, 16'h0004);
    check("t1_alu_op", alu_op, 0);
    check("t1_rsp0_early", rsp0_valid, 0);
    tick();
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_z", rsp0_z, 16'h0007);
    check("t1_rsp1_valid", rsp1_valid, 0);
    tick();
    check("t1_rsp0_done", rsp0_valid, 0);

    // Fresh pointer, then both valid for 6 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int k0, k1;
      k0 = 0; k1 = 0;
      for (int i = 0; i < 8; i++) begin
        req0_valid = (i < 6); req0_op = 4'd0; req0_x = 16'h0010 + 16'(k0); req0_y = 16'h0001;
        req1_valid = (i < 6); req1_op = 4'd1; req1_x = 16'h0100 + 16'(k1); req1_y = 16'h0001;
        #1;
        if (i < 6) begin
          check($sformatf("t2_gnt0_%0d", i), req0_ready, (i % 2 == 0));
          check($sformatf("t2_gnt1_%0d", i), req1_ready, (i % 2 == 1));
        end
        if (i >= 2) begin
          int j;
          logic [15:0] ez;
          j = i - 2;
          // req0 grant k: 0x10+k+1; req1 grant k: 0x100+k-1.
          ez = (j % 2 == 0) ? 16'h0011 + 16'(j / 2) : 16'h00FF + 16'(j / 2);
          check($sformatf("t2_rsp0_v_%0d", i), rsp0_valid, (j % 2 == 0));
          check($sformatf("t2_rsp1_v_%0d", i), rsp1_valid, (j % 2 == 1));
          check($sformatf("t2_z_%0d", i), (j % 2 == 0) ? rsp0_z : rsp1_z, ez);
        end
        tick();
        if (i < 6) begin
          if (i % 2 == 0) k0++;
          else            k1++;
        end
      end
      check("t2_idle0", rsp0_valid, 0);
      check("t2_idle1", rsp1_valid, 0);
    end

    // Backpressure on rsp0 with stage B and stage A both full. Pointer is at req0.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_x = 16'h0005; req0_y = 16'h0006;
    #1;
    check("t3_gntA", req0_ready, 1);
    tick();
    req0_x = 16'h0007; req0_y = 16'h0008;
    req1_valid = 1'b1; req1_op = 4'd4; req1_x = 16'h0020; req1_y = 16'h0003;
    #1;
    check("t3_gntC", req1_ready, 1);
    check("t3_noB", req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t3_rsp0_v_%0d", i), rsp0_valid, 1);
      check($sformatf("t3_rsp0_z_%0d", i), rsp0_z, 16'h000B);
      check($sformatf("t3_rdy0_%0d", i), req0_ready, 0);
      check($sformatf("t3_rdy1_%0d", i), req1_ready, 0);
      check($sformatf("t3_holdA_%0d", i), alu_x, 16'h0020);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("t3_rel_v", rsp0_valid, 1);
    check("t3_rel_z", rsp0_z, 16'h000B);
    check("t3_gntB", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t3_C_v", rsp1_valid, 1);
    check("t3_C_0", rsp0_valid, 0);
    check("t3_C_z", rsp1_z, 16'h0023);
    tick();
    check("t3_B_v", rsp0_valid, 1);
    check("t3_B_1", rsp1_valid, 0);
    check("t3_B_z", rsp0_z, 16'h000F);
    tick();
    check("t3_empty0", rsp0_valid, 0);
    check("t3_empty1", rsp1_valid, 0);

    // Only req1, four ops 0x1000 + y, y = 1..4.
    for (int i = 0; i < 6; i++) begin
      req1_valid = (i < 4); req1_op = 4'd0; req1_x = 16'h1000; req1_y = 16'(i + 1);
      #1;
      if (i < 4) begin
        check($sformatf("t4_gnt1_%0d", i), req1_ready, 1);
        check($sformatf("t4_gnt0_%0d", i), req0_ready, 0);
      end
      if (i >= 2) begin
        check($sformatf("t4_v_%0d", i), rsp1_valid, 1);
        check($sformatf("t4_z_%0d", i), rsp1_z, 16'h1000 + 16'(i - 1));
      end
      tick();
    end
    req1_valid = 1'b0;

    // Pointer must favour req0, then fill both stages and reset.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd2; req0_x = 16'h0055; req0_y = 16'h0066;
    req1_valid = 1'b1; req1_op = 4'd3; req1_x = 16'h0077; req1_y = 16'h0088;
    #1;
    check("t4_ptr_gnt0", req0_ready, 1);
    check("t4_ptr_gnt1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t5_gnt1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("t5_full_b", rsp0_valid, 1);
    check("t5_full_a", alu_x, 16'h0077);
    rst = 1'b1;
    tick();
    check("t5_rsp0_v", rsp0_valid, 0);
    check("t5_rsp1_v", rsp1_valid, 0);
    check("t5_alu_x", alu_x, 0);
    check("t5_alu_y", alu_y, 0);
    check("t5_alu_op", alu_op, 0);
    rst = 1'b0;
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_gnt0", req0_ready, 1);
    check("t5_gnt1_no", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("t5_no_stale", rsp0_valid | rsp1_valid, 0);

`ifdef ALU_ARB_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pc_rst0", gnt_cnt0, 0);
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    req1_valid = 1'b0;
    tick();
    check("pc_cnt0", gnt_cnt0, 5);
    check("pc_cnt1", gnt_cnt1, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
